// File: rtl/seg7_scan_driver_if.sv
// Load channel for the 7-segment scan driver: hex word, dp and blank masks.
// master drives s_valid/s_data/s_dp/s_blank, slave returns s_ready.
interface seg7_scan_driver_if;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [3:0]  s_dp;
    logic [3:0]  s_blank;

    modport master (
        output s_valid, s_data, s_dp, s_blank,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_data, s_dp, s_blank,
        output s_ready
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode 7-segment scan driver with guard gaps and a frame-synced load buffer.
// Ports: aclk, aresetn (sync, active low), s (load channel slave), dig[3:0], seg[7:0] (active low).
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to dark leading zero digits.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 50
) (
    input  logic                aclk,
    input  logic                aresetn,
    seg7_scan_driver_if.slave   s,
    output logic [3:0]          dig,
    output logic [7:0]          seg
);
    localparam int CW = $clog2(REFRESH_DIV > GUARD_CYC ? REFRESH_DIV : GUARD_CYC);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

    typedef enum logic {GUARD = 1'b0, SHOW = 1'b1} state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [1:0]    idx, nxt_idx;
    logic [15:0]   data_q, nxt_data;
    logic [3:0]    dp_q, nxt_dp;
    logic [3:0]    blank_q, nxt_blank;
    logic [15:0]   pend_data;
    logic [3:0]    pend_dp;
    logic [3:0]    pend_blank;
    logic          pend_full, nxt_pend_full;
    logic          accept, boundary, lz;
    logic [3:0]    nib;
    logic [3:0]    nxt_dig;
    logic [7:0]    nxt_seg;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] r;
        r = 7'h7F;
        case (n)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            4'hF: r = 7'h0E;
            default: r = 7'h7F;
        endcase
        return r;
    endfunction

    assign accept = s.s_valid & s.s_ready;

    // Outputs are registered from next-state values so dig/seg always
    // match the state register they are presented alongside.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 1'b1;
        nxt_idx   = idx;
        boundary  = 1'b0;
        unique case (state)
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    nxt_state = GUARD;
                    nxt_cnt   = '0;
                end
            end
            GUARD: begin
                if (cnt == GUARD_LAST) begin
                    nxt_state = SHOW;
                    nxt_cnt   = '0;
                    nxt_idx   = idx + 2'd1;
                    boundary  = (idx == 2'd3);
                end
            end
        endcase

        // Display regs only change at a frame boundary: no tearing.
        nxt_data  = data_q;
        nxt_dp    = dp_q;
        nxt_blank = blank_q;
        if (boundary && pend_full) begin
            nxt_data  = pend_data;
            nxt_dp    = pend_dp;
            nxt_blank = pend_blank;
        end
        // accept needs !pend_full, so it never coincides with a drain.
        nxt_pend_full = accept | (pend_full & ~boundary);

        nib = nxt_data[{~nxt_idx, 2'b00} +: 4];
        lz  = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lz = (nxt_idx != 2'd3);
        for (int i = 0; i < 3; i++) begin
            if (i <= int'(nxt_idx) && nxt_data[15-4*i -: 4] != 4'h0)
                lz = 1'b0;
        end
`endif

        nxt_dig = 4'hF;
        nxt_seg = 8'hFF;
        if (nxt_state == SHOW) begin
            nxt_dig = ~(4'b0001 << nxt_idx);
            if (!nxt_blank[nxt_idx])
                nxt_seg = {~nxt_dp[nxt_idx], lz ? 7'h7F : hex7(nib)};
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= GUARD;
            cnt        <= '0;
            idx        <= 2'd3;
            data_q     <= '0;
            dp_q       <= '0;
            blank_q    <= 4'hF;
            pend_full  <= 1'b0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            s.s_ready  <= 1'b1;
            dig        <= 4'hF;
            seg        <= 8'hFF;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            idx       <= nxt_idx;
            data_q    <= nxt_data;
            dp_q      <= nxt_dp;
            blank_q   <= nxt_blank;
            pend_full <= nxt_pend_full;
            if (accept) begin
                pend_data  <= s.s_data;
                pend_dp    <= s.s_dp;
                pend_blank <= s.s_blank;
            end
            s.s_ready <= ~nxt_pend_full;
            dig       <= nxt_dig;
            seg       <= nxt_seg;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, GUARD_CYC=2.
// Samples on the falling edge, drives inputs there too.
module tb_seg7_scan_driver;
    localparam int RD = 4;
    localparam int GC = 2;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] Z1 = 8'hFF, Z2 = 8'h7F, L0 = 8'hFF;
`else
    localparam logic [7:0] Z1 = 8'hC0, Z2 = 8'h40, L0 = 8'hC0;
`endif

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [3:0] dig;
    logic [7:0] seg;
    int         total = 0;
    int         bad = 0;

    seg7_scan_driver_if bus();

    seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD_CYC(GC)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s       (bus),
        .dig     (dig),
        .seg     (seg)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [3:0] de, input logic [7:0] se);
        total++;
        assert ({dig, seg} === {de, se}) else begin
            bad++;
            $error("FAIL %s dig=%h seg=%h expected dig=%h seg=%h", tag, dig, seg, de, se);
        end
        @(negedge aclk);
    endtask

    task automatic rdy(input string tag, input logic re);
        total++;
        assert (bus.s_ready === re) else begin
            bad++;
            $error("FAIL %s s_ready=%b expected %b", tag, bus.s_ready, re);
        end
    endtask

    task automatic digit(input string tag, input int d, input logic [7:0] se,
                         input int ns, input int ng);
        logic [3:0] de;
        de = ~(4'b0001 << d);
        repeat (ns) chk(tag, de, se);
        repeat (ng) chk(tag, 4'hF, 8'hFF);
    endtask

    task automatic frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
        digit(tag, 0, s0, RD, GC);
        digit(tag, 1, s1, RD, GC);
        digit(tag, 2, s2, RD, GC);
        digit(tag, 3, s3, RD, GC);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_dp    = p;
        bus.s_blank = b;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        @(negedge aclk);
        total++;
        assert ({dig, seg, bus.s_ready} === {4'hF, 8'hFF, 1'b1}) else begin
            bad++;
            $error("FAIL reset dig=%h seg=%h rdy=%b expected F FF 1", dig, seg, bus.s_ready);
        end
        aresetn = 1'b1;
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_dp    = '0;
        bus.s_blank = '0;
        @(negedge aclk);

        // idle scan after reset, display blanked
        do_reset();
        @(negedge aclk);
        chk("t1 gap", 4'hF, 8'hFF);
        frame("t1 scan", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        // load right after reset lands at the first frame boundary
        do_reset();
        load(16'h12AF, 4'h0, 4'h0);
        @(negedge aclk);
        rdy("t2 busy", 1'b0);
        bus.s_valid = 1'b0;
        chk("t2 gap", 4'hF, 8'hFF);
        rdy("t2 free", 1'b1);
        frame("t2 scan", 8'hF9, 8'hA4, 8'h88, 8'h8E);

        // A mid-frame, B held until A goes live
        load(16'h3456, 4'h0, 4'h0);
        chk("t3 old", 4'hE, 8'hF9);
        load(16'h789B, 4'h0, 4'h0);
        rdy("t3 full", 1'b0);
        digit("t3 old", 0, 8'hF9, RD - 1, GC);
        digit("t3 old", 1, 8'hA4, RD, GC);
        digit("t3 old", 2, 8'h88, RD, GC);
        digit("t3 old", 3, 8'h8E, RD, GC);
        rdy("t3 drained", 1'b1);
        chk("t3 A", 4'hE, 8'hB0);
        rdy("t3 B taken", 1'b0);
        bus.s_valid = 1'b0;
        digit("t3 A", 0, 8'hB0, RD - 1, GC);
        digit("t3 A", 1, 8'h99, RD, GC);
        digit("t3 A", 2, 8'h92, RD, GC);
        digit("t3 A", 3, 8'h82, RD, GC);
        rdy("t3 B live", 1'b1);

        // zeros with dp and blank masks
        load(16'h0000, 4'b0100, 4'b0001);
        chk("t4 B", 4'hE, 8'hF8);
        bus.s_valid = 1'b0;
        digit("t4 B", 0, 8'hF8, RD - 1, GC);
        digit("t4 B", 1, 8'h80, RD, GC);
        digit("t4 B", 2, 8'h90, RD, GC);
        digit("t4 B", 3, 8'h83, RD, GC);
        frame("t4 zero", 8'hFF, Z1, Z2, 8'hC0);

        // zero after a nonzero digit stays lit
        load(16'h0105, 4'h0, 4'h0);
        chk("t4b zero", 4'hE, 8'hFF);
        bus.s_valid = 1'b0;
        digit("t4b zero", 0, 8'hFF, RD - 1, GC);
        digit("t4b zero", 1, Z1, RD, GC);
        digit("t4b zero", 2, Z2, RD, GC);
        digit("t4b zero", 3, 8'hC0, RD, GC);
        frame("t4b scan", L0, 8'hF9, 8'hC0, 8'h92);

        // reset during digit 2 drops the pending load
        load(16'hFFFF, 4'hF, 4'h0);
        chk("t5 pre", 4'hE, L0);
        bus.s_valid = 1'b0;
        digit("t5 pre", 0, L0, RD - 1, GC);
        digit("t5 pre", 1, 8'hF9, RD, GC);
        chk("t5 pre", 4'hB, 8'hC0);
        do_reset();
        @(negedge aclk);
        chk("t5 gap", 4'hF, 8'hFF);
        frame("t5 scan", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        // accept on the boundary edge waits a whole frame
        digit("t6 pre", 0, 8'hFF, RD, GC);
        digit("t6 pre", 1, 8'hFF, RD, GC);
        digit("t6 pre", 2, 8'hFF, RD, GC);
        digit("t6 pre", 3, 8'hFF, RD, GC - 1);
        load(16'h4321, 4'h0, 4'h0);
        chk("t6 edge", 4'hF, 8'hFF);
        bus.s_valid = 1'b0;
        rdy("t6 held", 1'b0);
        frame("t6 wait", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        rdy("t6 free", 1'b1);
        frame("t6 scan", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
